// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECDH shared-secret to 3DES key path.
// Holds the key-deriver state encoding and DES key geometry.
package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ERR,
        BUILD,
        PRESENT
    } keyderiv_state_t;

    localparam int DES_KEY_W    = 64;
    localparam int DES_GROUP_W  = 7;
    localparam int DES_NUM_KEYS = 3;
    localparam int KEY_BITS     = 168;

endpackage

// File: rtl/des_odd_parity_byte.sv
// Turns a 7-bit key group into a DES key byte with odd parity in bit 0.
// Ports: grp (7-bit group in), pbyte (8-bit byte out, {grp, parity}).
module des_odd_parity_byte
    import ecc_pkg::*;
(
    input  logic [DES_GROUP_W-1:0] grp,
    output logic [7:0]             pbyte
);

    // Parity bit is set when the group already holds an even number of ones.
    assign pbyte = {grp, ~^grp};

endmodule

// File: rtl/ecdh_des_key_deriver.sv
// Captures SkX from the point multiplier and emits three odd-parity 3DES keys.
// Ports: clk, n_rst, pm_done, skx in; key_out, key_idx, key_valid, key_ready,
//        busy, err_zero, keys_done handshake/status.
module ecdh_des_key_deriver #(
    parameter int NUM_BITS = 163,
    parameter int KEY_BITS = 168
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                pm_done,
    input  logic [NUM_BITS:0]   skx,
    output logic [63:0]         key_out,
    output logic [1:0]          key_idx,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                busy,
    output logic                err_zero,
    output logic                keys_done
);

    import ecc_pkg::*;

    keyderiv_state_t state, state_nxt;

    logic [KEY_BITS-1:0] sr;
    logic [2:0]          cnt;
    logic [7:0]          pbyte;
    logic                last_key;

    des_odd_parity_byte u_par (
        .grp   (sr[KEY_BITS-1 -: DES_GROUP_W]),
        .pbyte (pbyte)
    );

    assign last_key  = (key_idx == 2'(DES_NUM_KEYS - 1));
    assign key_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign err_zero  = (state == ERR);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pm_done) begin
                    state_nxt = (skx == '0) ? ERR : BUILD;
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            BUILD: begin
                if (cnt == 3'd7) begin
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (key_ready) begin
                    state_nxt = last_key ? IDLE : BUILD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            key_out   <= '0;
            key_idx   <= '0;
            keys_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            keys_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pm_done) begin
                        sr      <= KEY_BITS'(skx);
                        key_idx <= '0;
                        cnt     <= '0;
                    end
                end
                BUILD: begin
                    key_out <= {key_out[55:0], pbyte};
                    sr      <= sr << DES_GROUP_W;
                    cnt     <= cnt + 3'd1;
                end
                PRESENT: begin
                    if (key_ready) begin
                        cnt <= '0;
                        if (last_key) begin
                            keys_done <= 1'b1;
                        end else begin
                            key_idx <= key_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
